debug_frame_serializer: RTL and testbench



---
 rtl/debug_frame_serializer.sv | 161 ++++++++++++++++
 tb/tb_debug_frame_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_serializer.sv
// debug_frame_serializer
//   Captures a snapshot of NUM_WORDS 32-bit pipeline words on a start request
//   and streams it into the UART TX FIFO as a framed byte sequence:
//   header, word count, payload (word 0 first, each word little-endian), and
//   an 8-bit checksum (mod-256 sum of count and payload bytes).
//
// Ports
//   clock             in   system clock, rising edge
//   reset             in   synchronous, active-high reset
//   start             in   capture snapshot and send one frame (ignored unless idle)
//   snapshot          in   NUM_WORDS*32 packed words, word k at [32k+31:32k]
//   fifoFull          in   TX FIFO cannot accept a byte this cycle
//   dataToUartOutFifo out  byte presented to the FIFO (registered, held while stalled)
//   writeFifoFlag     out  write strobe (combinational: emitting state and not full)
//   busy              out  frame in progress (registered)
//   done              out  one-cycle pulse after the checksum byte is written
module debug_frame_serializer #(
    parameter int unsigned NUM_WORDS   = 16,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_WORDS*32-1:0] snapshot,
    input  logic                    fifoFull,
    output logic [7:0]              dataToUartOutFifo,
    output logic                    writeFifoFlag,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned SNAP_W    = NUM_WORDS * 32;
    localparam int unsigned NUM_BYTES = NUM_WORDS * 4;
    localparam int unsigned WIDX_W    = 8;
    localparam int unsigned BIDX_W    = 2;
    localparam int unsigned PIDX_W    = WIDX_W + BIDX_W;

    localparam logic [7:0]        COUNT_BYTE = 8'(NUM_WORDS);
    localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(NUM_WORDS - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CNT,
        ST_PAY,
        ST_CHK,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [WIDX_W-1:0]   word_q, word_d;
    logic [BIDX_W-1:0]   byte_q, byte_d;
    logic [7:0]          chk_q, chk_d;
    logic [7:0]          data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                emit;
    logic                accept;
    logic [7:0]          pay_byte;

    // A byte transfers whenever an emitting state meets a non-full FIFO
    assign emit   = (state_q == ST_HDR) || (state_q == ST_CNT) ||
                    (state_q == ST_PAY) || (state_q == ST_CHK);
    assign accept = emit && !fifoFull;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            word_q  <= '0;
            byte_q  <= '0;
            chk_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            chk_q   <= chk_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; emitting states advance only on an accepted write
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)  state_d = ST_HDR;
            ST_HDR:  if (accept) state_d = ST_CNT;
            ST_CNT:  if (accept) state_d = ST_PAY;
            ST_PAY:  if (accept && (word_q == LAST_WORD) && (byte_q == LAST_BYTE))
                         state_d = ST_CHK;
            ST_CHK:  if (accept) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output logic; the output byte is precomputed for the
    // state being entered so it is valid on the first strobe cycle
    always_comb begin
        snap_d        = snap_q;
        word_d        = word_q;
        byte_d        = byte_q;
        chk_d         = chk_q;
        writeFifoFlag = accept;

        if ((state_q == ST_IDLE) && start) begin
            snap_d = snapshot;
            word_d = '0;
            byte_d = '0;
            chk_d  = '0;
        end

        if (accept && (state_q == ST_CNT)) begin
            chk_d = chk_q + COUNT_BYTE;
        end

        // data_q holds the payload byte being written, so it feeds the sum
        if (accept && (state_q == ST_PAY)) begin
            chk_d  = chk_q + data_q;
            byte_d = byte_q + BIDX_W'(1);
            if (byte_q == LAST_BYTE) begin
                word_d = word_q + WIDX_W'(1);
            end
        end

        // Payload byte at the next index; {word,byte} is the flat byte number
        pay_byte = '0;
        for (int unsigned k = 0; k < NUM_BYTES; k++) begin
            if ({word_d, byte_d} == PIDX_W'(k)) begin
                pay_byte = snap_q[k*8 +: 8];
            end
        end

        case (state_d)
            ST_HDR:  data_d = HEADER_BYTE;
            ST_CNT:  data_d = COUNT_BYTE;
            ST_PAY:  data_d = pay_byte;
            ST_CHK:  data_d = chk_d;
            default: data_d = 8'h00;
        endcase

        busy_d = (state_d == ST_HDR) || (state_d == ST_CNT) ||
                 (state_d == ST_PAY) || (state_d == ST_CHK);
        done_d = (state_d == ST_DONE);
    end

    assign dataToUartOutFifo = data_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_debug_frame_serializer.sv
// tb_debug_frame_serializer
//   Two serializers (NUM_WORDS=2 and NUM_WORDS=1) share start, fifoFull and
//   the low snapshot word. A negedge monitor collects every strobed byte and
//   the done/busy activity; each frame is compared to a byte list built
//   directly from the frame format.
module tb_debug_frame_serializer;

    typedef logic [7:0] bq_t[$];

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        start_i = 1'b0;
    logic        full_i  = 1'b0;
    logic [63:0] snap_i  = '0;

    logic [7:0]  data_a, data_b;
    logic        wr_a, wr_b, busy_a, busy_b, done_a, done_b;

    int n_checks = 0;
    int n_errors = 0;

    int  cyc  = 0;
    int  cyc0 = 0;
    bit  mon_en = 1'b0;
    bq_t qa, qb;
    int  done_n_a, done_n_b, done_c_a, done_c_b;
    int  last_a, last_b, busy_n_a, busy_n_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debug_frame_serializer #(.NUM_WORDS(2), .HEADER_BYTE(8'hA5)) u_dut_a (
        .clock             (clk),
        .reset             (rst),
        .start             (start_i),
        .snapshot          (snap_i),
        .fifoFull          (full_i),
        .dataToUartOutFifo (data_a),
        .writeFifoFlag     (wr_a),
        .busy              (busy_a),
        .done              (done_a)
    );

    debug_frame_serializer #(.NUM_WORDS(1), .HEADER_BYTE(8'hA5)) u_dut_b (
        .clock             (clk),
        .reset             (rst),
        .start             (start_i),
        .snapshot          (snap_i[31:0]),
        .fifoFull          (full_i),
        .dataToUartOutFifo (data_b),
        .writeFifoFlag     (wr_b),
        .busy              (busy_b),
        .done              (done_b)
    );

    // Monitor: sample outputs mid-cycle, cycle numbers relative to start cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_a) begin qa.push_back(data_a); last_a = cyc - cyc0; end
            if (wr_b) begin qb.push_back(data_b); last_b = cyc - cyc0; end
            if (done_a) begin done_n_a++; done_c_a = cyc - cyc0; end
            if (done_b) begin done_n_b++; done_c_b = cyc - cyc0; end
            if (busy_a) busy_n_a++;
            if (busy_b) busy_n_b++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: header, count, little-endian payload, mod-256 sum
    function automatic bq_t build(input int nw, input logic [63:0] snap);
        bq_t         q;
        logic [7:0]  sum;
        logic [63:0] s;
        q.push_back(8'hA5);
        q.push_back(8'(nw));
        sum = 8'(nw);
        s   = snap;
        for (int i = 0; i < 4 * nw; i++) begin
            q.push_back(s[7:0]);
            sum = sum + s[7:0];
            s   = s >> 8;
        end
        q.push_back(sum);
        return q;
    endfunction

    task automatic compare_stream(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        foreach (exp[i])
            check($sformatf("%s[%0d]", tag, i),
                  (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    // mode: 0 never full, 1 five-cycle stall on 4th byte, 2 full on odd cycles, 3 random
    task automatic run_frame(input logic [63:0] snap, input int mode, input int extra_start,
                             input bit corrupt, input int abort_at);
        int c;
        int stall_left;
        bit aborted;
        qa.delete(); qb.delete();
        done_n_a = 0; done_n_b = 0; done_c_a = -1; done_c_b = -1;
        last_a = -1; last_b = -1; busy_n_a = 0; busy_n_b = 0;
        cyc0    = cyc;
        mon_en  = 1'b1;
        snap_i  = snap;
        start_i = 1'b1;
        full_i  = 1'b0;
        tick();
        start_i = 1'b0;
        if (corrupt) snap_i = '1;
        stall_left = 5;
        aborted    = 1'b0;
        c = 1;
        while (done_n_a == 0 && c < 300) begin
            start_i = (c == extra_start);
            full_i  = 1'b0;
            case (mode)
                1: if (qa.size() == 3 && stall_left > 0) begin full_i = 1'b1; stall_left--; end
                2: full_i = c[0];
                3: full_i = ($urandom_range(0, 2) == 0);
                default: full_i = 1'b0;
            endcase
            if (abort_at > 0 && qa.size() == abort_at - 1) begin
                rst = 1'b1;
                tick();
                @(negedge clk);
                check("abort_wr_a",   32'(wr_a),   32'd0);
                check("abort_busy_a", 32'(busy_a), 32'd0);
                check("abort_done_a", 32'(done_a), 32'd0);
                check("abort_data_a", 32'(data_a), 32'd0);
                check("abort_wr_b",   32'(wr_b),   32'd0);
                rst = 1'b0;
                tick();
                aborted = 1'b1;
                break;
            end
            if (mode == 1 && full_i) begin
                @(negedge clk);
                check("stall_data_a", 32'(data_a), 32'hCC);
                check("stall_wr_a",   32'(wr_a),   32'd0);
            end
            tick();
            c++;
        end
        full_i  = 1'b0;
        start_i = 1'b0;
        if (!aborted && done_n_a == 0) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic verify_frame(input string tag, input logic [63:0] snap,
                                input int exp_da, input int exp_db);
        compare_stream({tag, "_a"}, qa, build(2, snap));
        compare_stream({tag, "_b"}, qb, build(1, snap));
        check({tag, "_done_n_a"}, 32'(done_n_a), 32'd1);
        check({tag, "_done_n_b"}, 32'(done_n_b), 32'd1);
        check({tag, "_done_lat_a"}, 32'(done_c_a), 32'(last_a + 1));
        check({tag, "_done_lat_b"}, 32'(done_c_b), 32'(last_b + 1));
        check({tag, "_busy_a"}, 32'(busy_n_a), 32'(done_c_a - 1));
        check({tag, "_busy_b"}, 32'(busy_n_b), 32'(done_c_b - 1));
        if (exp_da >= 0) check({tag, "_done_cyc_a"}, 32'(done_c_a), 32'(exp_da));
        if (exp_db >= 0) check({tag, "_done_cyc_b"}, 32'(done_c_b), 32'(exp_db));
    endtask

    initial begin
        bq_t         nominal;
        bq_t         ones_b;
        bq_t         ref_a;
        logic [63:0] base;
        logic [63:0] rs;
        int          sz;

        base    = 64'h11223344_AABBCCDD;
        nominal = '{8'hA5, 8'h02, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                   8'h44, 8'h33, 8'h22, 8'h11, 8'hBA};
        ones_b  = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_data_a", 32'(data_a), 32'd0);
        check("rst_wr_a",   32'(wr_a),   32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        tick();

        // Nominal frame, no back-pressure
        run_frame(base, 0, -1, 1'b0, 0);
        compare_stream("nominal_const", qa, nominal);
        verify_frame("nominal", base, 12, 8);

        // Five-cycle stall on the CC byte, started back-to-back after DONE
        run_frame(base, 1, -1, 1'b0, 0);
        verify_frame("stall", base, 17, 13);

        // Snapshot changes right after start; latched copy must be sent
        run_frame(base, 0, -1, 1'b1, 0);
        verify_frame("latched", base, 12, 8);

        // start during an active frame is ignored
        run_frame(base, 0, 4, 1'b0, 0);
        verify_frame("restart_ignored", base, 12, 8);
        tick(); tick(); tick();
        check("no_second_frame_a", 32'(qa.size()), 32'd11);
        check("no_second_done_a",  32'(done_n_a),  32'd1);

        // Reset after the 6th strobe aborts the frame for good
        run_frame(base, 0, -1, 1'b0, 6);
        tick(); tick(); tick(); tick();
        sz    = qa.size();
        ref_a = build(2, base);
        check("abort_strobes_a", 32'(sz), 32'd6);
        check("abort_strobes_b", 32'(qb.size()), 32'd6);
        check("abort_no_done_a", 32'(done_n_a), 32'd0);
        check("abort_no_done_b", 32'(done_n_b), 32'd0);
        for (int i = 0; i < 6 && i < sz; i++)
            check($sformatf("abort_prefix[%0d]", i), 32'(qa[i]), 32'(ref_a[i]));
        run_frame(base, 0, -1, 1'b0, 0);
        verify_frame("after_abort", base, 12, 8);

        // Checksum wrap on the single-word instance
        run_frame(64'h0BAD_F00D_FFFF_FFFF, 0, -1, 1'b0, 0);
        compare_stream("ones_const", qb, ones_b);
        verify_frame("ones", 64'h0BAD_F00D_FFFF_FFFF, 12, 8);

        // fifoFull toggling every cycle: same stream, stretched
        run_frame(base, 2, -1, 1'b0, 0);
        verify_frame("toggle", base, -1, -1);

        // Random snapshots under random back-pressure
        for (int n = 0; n < 12; n++) begin
            rs = {$urandom(), $urandom()};
            run_frame(rs, 3, -1, 1'b0, 0);
            verify_frame($sformatf("rand%0d", n), rs, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
